// File: rtl/apb_traffic_gen.sv
// apb_traffic_gen: LFSR-driven APB request generator usable as a synthesizable bus self-test.
// Issues write, read or write+readback items with a fixed idle gap and tallies the outcome.
module apb_traffic_gen #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h1000_0000),
    parameter int                SPAN_W    = 14,
    parameter int                GAP       = 5,
    parameter int                TIMEOUT   = 256,
    parameter logic [31:0]       SEED      = 32'hACE1_2345
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [15:0]       num_txn,
    output logic              transfer,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       txn_count,
    output logic [15:0]       err_count,
    output logic              timeout_err
);

    // state      | meaning
    // S_IDLE     | waiting for start
    // S_GEN      | build addr/wdata from the LFSR (two steps)
    // S_ISSUE    | transfer pulse for the main access
    // S_WAIT     | waiting for ready on the main access
    // S_RB_ISSUE | transfer pulse for the readback
    // S_RB_WAIT  | waiting for ready on the readback, compare rdata
    // S_GAP      | idle cycles between items
    // S_FIN      | raise done, drop busy
    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_ISSUE, S_WAIT, S_RB_ISSUE, S_RB_WAIT, S_GAP, S_FIN
    } state_t;

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP + 2);
    // WAIT starts one edge after the transfer pulse, so expiry lands on the TIMEOUT-th edge
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 2);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [31:0]      POLY     = 32'h8020_0003;

    state_t            state_q, state_nxt, after_item;
    logic [31:0]       lfsr_q, lfsr_nxt, lfsr_s1;
    logic [1:0]        mode_q, mode_nxt;
    logic [15:0]       rem_q, rem_nxt;
    logic [TMR_W-1:0]  tmr_q, tmr_nxt;
    logic [GAP_W-1:0]  gap_q, gap_nxt;
    logic [DATA_W-1:0] exp_q, exp_nxt;
    logic [ADDR_W-1:0] offset;
    logic              transfer_nxt, write_nxt, busy_nxt, done_nxt, timeout_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [15:0]       txn_nxt, err_nxt;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
    endfunction

    always_comb begin
        lfsr_s1 = lfsr_step(lfsr_q);
        offset = '0;
        offset[SPAN_W-1:2] = lfsr_q[SPAN_W-1:2];
        after_item = (rem_q == 16'd1) ? S_FIN : ((GAP == 0) ? S_GEN : S_GAP);

        state_nxt    = state_q;
        lfsr_nxt     = lfsr_q;
        mode_nxt     = mode_q;
        rem_nxt      = rem_q;
        tmr_nxt      = tmr_q;
        gap_nxt      = gap_q;
        exp_nxt      = exp_q;
        transfer_nxt = 1'b0;
        done_nxt     = 1'b0;
        write_nxt    = write;
        addr_nxt     = addr;
        wdata_nxt    = wdata;
        busy_nxt     = busy;
        txn_nxt      = txn_count;
        err_nxt      = err_count;
        timeout_nxt  = timeout_err;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_nxt    = (mode == 2'd3) ? 2'd0 : mode;
                    rem_nxt     = num_txn;
                    txn_nxt     = '0;
                    err_nxt     = '0;
                    timeout_nxt = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = (num_txn == 16'd0) ? S_FIN : S_GEN;
                end
            end
            S_GEN: begin
                addr_nxt     = BASE_ADDR + offset;
                wdata_nxt    = lfsr_s1[DATA_W-1:0];
                lfsr_nxt     = lfsr_step(lfsr_s1);
                write_nxt    = (mode_q != 2'd1);
                transfer_nxt = 1'b1;
                state_nxt    = S_ISSUE;
            end
            S_ISSUE, S_RB_ISSUE: begin
                tmr_nxt   = TMR_LOAD;
                state_nxt = (state_q == S_ISSUE) ? S_WAIT : S_RB_WAIT;
            end
            S_WAIT, S_RB_WAIT: begin
                if (ready) begin
                    if (state_q == S_WAIT && mode_q == 2'd2) begin
                        exp_nxt      = wdata;
                        write_nxt    = 1'b0;
                        transfer_nxt = 1'b1;
                        state_nxt    = S_RB_ISSUE;
                    end else begin
                        if (state_q == S_RB_WAIT && rdata != exp_q && err_count != 16'hFFFF)
                            err_nxt = err_count + 16'd1;
                        txn_nxt   = txn_count + 16'd1;
                        rem_nxt   = rem_q - 16'd1;
                        gap_nxt   = GAP_LOAD;
                        state_nxt = after_item;
                    end
                end else if (tmr_q == '0) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_FIN;
                end else begin
                    tmr_nxt = tmr_q - 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == '0)
                    state_nxt = S_GEN;
                else
                    gap_nxt = gap_q - 1'b1;
            end
            S_FIN: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            mode_q      <= '0;
            rem_q       <= '0;
            tmr_q       <= '0;
            gap_q       <= '0;
            exp_q       <= '0;
            transfer    <= 1'b0;
            write       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            txn_count   <= '0;
            err_count   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            lfsr_q      <= lfsr_nxt;
            mode_q      <= mode_nxt;
            rem_q       <= rem_nxt;
            tmr_q       <= tmr_nxt;
            gap_q       <= gap_nxt;
            exp_q       <= exp_nxt;
            transfer    <= transfer_nxt;
            write       <= write_nxt;
            addr        <= addr_nxt;
            wdata       <= wdata_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            txn_count   <= txn_nxt;
            err_count   <= err_nxt;
            timeout_err <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_apb_traffic_gen.sv
// Bench for apb_traffic_gen: random runs checked against an arithmetic model of the
// LFSR item stream, with a memory-model APB slave answering two cycles after transfer.
module tb_apb_traffic_gen;

    localparam int          GAP     = 5;
    localparam int          TIMEOUT = 256;
    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam logic [31:0] SEED    = 32'hACE1_2345;
    localparam logic [31:0] POLY    = 32'h8020_0003;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] num_txn = 16'd0;
    logic [31:0] rdata = 32'd0;
    logic        ready = 1'b0;
    logic        transfer, write, busy, done, timeout_err;
    logic [31:0] addr, wdata;
    logic [15:0] txn_count, err_count;

    apb_traffic_gen #(
        .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .SPAN_W(14),
        .GAP(GAP), .TIMEOUT(TIMEOUT), .SEED(SEED)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .start(start), .mode(mode), .num_txn(num_txn),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .done(done),
        .txn_count(txn_count), .err_count(err_count), .timeout_err(timeout_err)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } xfer_t;

    xfer_t xlog[$];
    xfer_t rlog[$];
    int    done_total = 0;
    int    to_rise_cyc = -1;
    logic  slave_on = 1'b1;
    int    rd_total = 0;
    int    corrupt_a = -1;
    int    corrupt_b = -1;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] m_lfsr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        logic to_prev;
        to_prev = 1'b0;
        forever begin
            @(negedge PCLK);
            if (transfer) xlog.push_back('{write, addr, wdata, cyc});
            if (done) done_total++;
            if (timeout_err && !to_prev) to_rise_cyc = cyc;
            to_prev = timeout_err;
        end
    end

    // Slave: ready for one cycle, two cycles after each transfer pulse
    initial begin
        int          cnt;
        logic        cw;
        logic [31:0] ca, cd;
        cnt = -1; cw = 1'b0; ca = '0; cd = '0;
        forever begin
            @(posedge PCLK);
            #1;
            ready = 1'b0;
            if (PRESET) begin
                cnt = -1;
            end else begin
                if (cnt > 0) cnt--;
                if (cnt == 0) begin
                    cnt = -1;
                    rlog.push_back('{write, addr, wdata, cyc});
                    if (cw) begin
                        mem[ca] = cd;
                    end else begin
                        rd_total++;
                        rdata = mem.exists(ca) ? mem[ca] : $urandom;
                        if (rd_total == corrupt_a || rd_total == corrupt_b) rdata[0] = ~rdata[0];
                    end
                    ready = 1'b1;
                end
                if (transfer && slave_on) begin
                    cnt = 2; cw = write; ca = addr; cd = wdata;
                end
            end
        end
    end

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    task automatic gen_item(output logic [31:0] a, output logic [31:0] d);
        logic [31:0] s1;
        a      = BASE + ((m_lfsr % 32'h4000) / 4) * 4;
        s1     = lfsr_next(m_lfsr);
        d      = s1;
        m_lfsr = lfsr_next(s1);
    endtask

    task automatic check_items(input logic [1:0] m, input int n, input int x0, input int r0,
                               input bit resp);
        int          per, j;
        logic [31:0] a, d;
        logic        ewr;
        per = (m == 2'd2) ? 2 : 1;
        j   = 0;
        chk("xfer_count", 32'(xlog.size() - x0), 32'(n * per));
        if (resp) chk("ready_count", 32'(rlog.size() - r0), 32'(n * per));
        for (int i = 0; i < n; i++) begin
            gen_item(a, d);
            for (int p = 0; p < per; p++) begin
                ewr = (m == 2'd1) ? 1'b0 : (p == 0);
                if (x0 + j < xlog.size()) begin
                    chk("xfer_write", 32'(xlog[x0+j].wr), 32'(ewr));
                    chk("xfer_addr", xlog[x0+j].a, a);
                    chk("xfer_wdata", xlog[x0+j].d, d);
                    chk("addr_in_span", 32'(xlog[x0+j].a >= BASE && xlog[x0+j].a <= BASE + 32'h3FFC), 1);
                    chk("addr_aligned", 32'(xlog[x0+j].a[1:0]), 0);
                end
                if (resp && r0 + j < rlog.size()) begin
                    chk("hold_write", 32'(rlog[r0+j].wr), 32'(ewr));
                    chk("hold_addr", rlog[r0+j].a, a);
                    chk("hold_wdata", rlog[r0+j].d, d);
                end
                j++;
            end
        end
    endtask

    task automatic pulse_start(input logic [1:0] m, input int n);
        @(negedge PCLK);
        mode = m; num_txn = 16'(n); start = 1'b1;
        @(negedge PCLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge PCLK);
            k++;
        end
        chk("done_in_time", 32'(done), 1);
        @(negedge PCLK);
    endtask

    task automatic end_checks(input int d0, input int txn, input int err, input logic to);
        chk("done_once", 32'(done_total - d0), 1);
        chk("busy_after", 32'(busy), 0);
        chk("txn_count", 32'(txn_count), 32'(txn));
        chk("err_count", 32'(err_count), 32'(err));
        chk("timeout_err", 32'(timeout_err), 32'(to));
    endtask

    task automatic wait_transfer();
        int k;
        k = 0;
        while (!transfer && k < 50) begin
            @(negedge PCLK);
            k++;
        end
        chk("xfer_seen", 32'(transfer), 1);
    endtask

    initial begin
        int x0, r0, d0, n;
        m_lfsr = SEED;
        repeat (3) @(negedge PCLK);
        chk("rst_transfer", 32'(transfer), 0);
        chk("rst_write", 32'(write), 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_txn", 32'(txn_count), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        PRESET = 1'b0;

        // mode 0, three items, gap spacing
        x0 = xlog.size(); r0 = rlog.size(); d0 = done_total;
        pulse_start(2'd0, 3);
        wait_done(200);
        if (xlog.size() >= x0 + 3) begin
            chk("gap_spacing_1", 32'(xlog[x0+1].c - xlog[x0].c), 32'(4 + GAP));
            chk("gap_spacing_2", 32'(xlog[x0+2].c - xlog[x0+1].c), 32'(4 + GAP));
        end
        check_items(2'd0, 3, x0, r0, 1'b1);
        end_checks(d0, 3, 0, 1'b0);

        // mode 1, random length, reads not compared
        n = $urandom_range(2, 6);
        x0 = xlog.size(); r0 = rlog.size(); d0 = done_total;
        pulse_start(2'd1, n);
        wait_done(40 * n + 50);
        check_items(2'd1, n, x0, r0, 1'b1);
        end_checks(d0, n, 0, 1'b0);

        // mode 3 behaves as mode 0
        n = $urandom_range(1, 4);
        x0 = xlog.size(); r0 = rlog.size(); d0 = done_total;
        pulse_start(2'd3, n);
        wait_done(40 * n + 50);
        check_items(2'd0, n, x0, r0, 1'b1);
        end_checks(d0, n, 0, 1'b0);

        // mode 2, 100 items with faithful memory
        x0 = xlog.size(); r0 = rlog.size(); d0 = done_total;
        pulse_start(2'd2, 100);
        wait_done(3000);
        check_items(2'd2, 100, x0, r0, 1'b1);
        end_checks(d0, 100, 0, 1'b0);

        // mode 2 with corrupted readbacks on items 5 and 9
        corrupt_a = rd_total + 5;
        corrupt_b = rd_total + 9;
        x0 = xlog.size(); r0 = rlog.size(); d0 = done_total;
        pulse_start(2'd2, 12);
        wait_done(500);
        check_items(2'd2, 12, x0, r0, 1'b1);
        end_checks(d0, 12, 2, 1'b0);
        corrupt_a = -1; corrupt_b = -1;

        // slave silent: timeout after TIMEOUT cycles
        slave_on = 1'b0;
        x0 = xlog.size(); r0 = rlog.size(); d0 = done_total;
        pulse_start(2'd0, 4);
        wait_done(TIMEOUT + 100);
        if (xlog.size() > x0)
            chk("timeout_cycles", 32'(to_rise_cyc - xlog[x0].c), 32'(TIMEOUT));
        check_items(2'd0, 1, x0, r0, 1'b0);
        end_checks(d0, 0, 0, 1'b1);
        slave_on = 1'b1;

        // next accepted start clears timeout_err
        x0 = xlog.size(); r0 = rlog.size(); d0 = done_total;
        pulse_start(2'd0, 1);
        wait_done(100);
        check_items(2'd0, 1, x0, r0, 1'b1);
        end_checks(d0, 1, 0, 1'b0);

        // num_txn = 0: done two edges after start, no transfer
        x0 = xlog.size(); d0 = done_total;
        pulse_start(2'd0, 0);
        chk("zero_done_e0", 32'(done), 0);
        chk("zero_busy_e0", 32'(busy), 1);
        @(negedge PCLK);
        chk("zero_done_e1", 32'(done), 1);
        chk("zero_busy_e1", 32'(busy), 0);
        @(negedge PCLK);
        chk("zero_done_e2", 32'(done), 0);
        chk("zero_xfers", 32'(xlog.size() - x0), 0);
        chk("zero_txn", 32'(txn_count), 0);
        chk("zero_done_once", 32'(done_total - d0), 1);

        // start while busy is ignored
        x0 = xlog.size(); r0 = rlog.size(); d0 = done_total;
        pulse_start(2'd0, 2);
        repeat (2) @(negedge PCLK);
        chk("busy_mid_run", 32'(busy), 1);
        mode = 2'd1; num_txn = 16'd7; start = 1'b1;
        @(negedge PCLK);
        start = 1'b0;
        wait_done(200);
        check_items(2'd0, 2, x0, r0, 1'b1);
        end_checks(d0, 2, 0, 1'b0);

        // async reset mid-WAIT, then while transfer is high
        slave_on = 1'b0;
        pulse_start(2'd0, 5);
        wait_transfer();
        @(negedge PCLK);
        #2 PRESET = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_addr", addr, 0);
        chk("arst_write", 32'(write), 0);
        chk("arst_wdata", wdata, 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        pulse_start(2'd0, 2);
        wait_transfer();
        #2 PRESET = 1'b1;
        #1;
        chk("arst_transfer", 32'(transfer), 0);
        chk("arst_busy2", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        slave_on = 1'b1;
        m_lfsr = SEED;

        // after reset the item stream restarts from SEED
        x0 = xlog.size(); r0 = rlog.size(); d0 = done_total;
        pulse_start(2'd0, 3);
        wait_done(200);
        check_items(2'd0, 3, x0, r0, 1'b1);
        end_checks(d0, 3, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
